// File: rtl/tristate_bus_pkg.sv
// Shared types and defaults for the tri-state bus arbiter.
package tristate_bus_pkg;

  localparam int unsigned DefNumReq  = 4;
  localparam int unsigned DefTurnCyc = 1;
  localparam int unsigned DefTimeout = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn  = 2'd1,
    StTurn = 2'd2
  } arb_state_e;

  // Width of an index over n items, never narrower than one bit.
  function automatic int unsigned owner_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Requester/bus-driver signal bundle; master is the arbiter side, slave the agent side.
interface tristate_bus_arbiter_if
  import tristate_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq
) ();

  localparam int unsigned IdW = owner_id_w(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] last;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] drv_en_n;
  logic               bus_busy;
  logic [IdW-1:0]     owner_id;
  logic               timeout;

  modport master (
    input  req,
    input  last,
    output gnt,
    output drv_en_n,
    output bus_busy,
    output owner_id,
    output timeout
  );

  modport slave (
    output req,
    output last,
    input  gnt,
    input  drv_en_n,
    input  bus_busy,
    input  owner_id,
    input  timeout
  );

endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick
  import tristate_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IdW    = owner_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IdW-1:0]     idx,
  output logic               any
);

  int unsigned    pos;
  logic [IdW-1:0] pos_idx;

  always_comb begin
    onehot  = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      pos_idx = IdW'(pos);
      if (!any && req[pos_idx]) begin
        any             = 1'b1;
        idx             = pos_idx;
        onehot[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus with forced turnaround gaps.
// Optional forced release after TIMEOUT owned cycles when BUS_TIMEOUT_EN is defined.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DefNumReq,
  parameter int unsigned TURN_CYC = DefTurnCyc,
  parameter int unsigned TIMEOUT  = DefTimeout
) (
  input logic                    clk,
  input logic                    rst_n,
  tristate_bus_arbiter_if.master bus
);

  localparam int unsigned      IdW      = owner_id_w(NUM_REQ);
  localparam int unsigned      TurnW    = owner_id_w(TURN_CYC);
  localparam logic [IdW-1:0]   LastId   = IdW'(NUM_REQ - 1);
  localparam logic [TurnW-1:0] TurnLoad = TurnW'(TURN_CYC - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] drv_q, drv_d;
  logic               busy_q, busy_d;
  logic [IdW-1:0]     owner_q, owner_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [TurnW-1:0]   turn_q, turn_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IdW-1:0]     pick_idx;
  logic               pick_any;
  logic               grant_now;
  logic               release_req;
  logic               forced_rel;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned OccW = owner_id_w(TIMEOUT);
  logic [OccW-1:0] occ_q, occ_d;
  logic            tmo_q, tmo_d;
  assign forced_rel = (occ_q == OccW'(TIMEOUT - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign forced_rel = 1'b0;
`endif

  // Only the current owner's req/last bits can end a tenure.
  assign release_req = !bus.req[owner_q] || bus.last[owner_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    turn_d    = turn_q;
    grant_now = 1'b0;
`ifdef BUS_TIMEOUT_EN
    occ_d     = occ_q;
    tmo_d     = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_now = 1'b1;
        end
      end
      StOwn: begin
        if (release_req || forced_rel) begin
          state_d = StTurn;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = (owner_q == LastId) ? '0 : owner_q + IdW'(1);
          turn_d  = TurnLoad;
`ifdef BUS_TIMEOUT_EN
          tmo_d   = forced_rel && !release_req;
`endif
        end else begin
`ifdef BUS_TIMEOUT_EN
          occ_d = occ_q + OccW'(1);
`endif
        end
      end
      StTurn: begin
        if (turn_q == '0) begin
          // Turnaround done: hand straight to a waiting requester if there is one.
          if (pick_any) begin
            grant_now = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          turn_d = turn_q - TurnW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (grant_now) begin
      state_d = StOwn;
      gnt_d   = pick_onehot;
      busy_d  = 1'b1;
      owner_d = pick_idx;
`ifdef BUS_TIMEOUT_EN
      occ_d   = '0;
`endif
    end

    drv_d = ~gnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      drv_q   <= '1;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      turn_q  <= turn_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.timeout = tmo_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt      = gnt_q;
  assign bus.drv_en_n = drv_q;
  assign bus.bus_busy = busy_q;
  assign bus.owner_id = owner_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: grant-order scoreboard plus per-cycle bus invariants.
module tb_tristate_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TC = 1;
  localparam int unsigned TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int tmo_cnt   = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] inv_g;
  logic [N-1:0] exp_g;

  tristate_bus_arbiter_if #(.NUM_REQ(N)) bus ();

  tristate_bus_arbiter #(
    .NUM_REQ (N),
    .TURN_CYC(TC),
    .TIMEOUT (TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 20);
    check(tag, 32'(bus.gnt != '0), 1);
  endtask

  // Per-cycle invariants and grant-order scoreboard.
  always @(negedge clk) begin
    inv_g = ~bus.gnt;
    check("drv_en_n_inv", 32'(bus.drv_en_n), 32'(inv_g));
    check("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
    check("busy_vs_gnt", 32'(bus.bus_busy), 32'(|bus.gnt));
    if (bus.timeout === 1'b1) tmo_cnt++;
    if (bus.gnt != '0 && prev_gnt == '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(bus.gnt), 0);
      end else begin
        exp_g = exp_q.pop_front();
        check("grant_order", 32'(bus.gnt), 32'(exp_g));
      end
    end
    prev_gnt = bus.gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;
    int owned;
    bus.req  = '0;
    bus.last = '0;
    rst_n    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_drv", 32'(bus.drv_en_n), 32'hF);
    check("rst_busy", 32'(bus.bus_busy), 0);
    check("rst_owner", 32'(bus.owner_id), 0);
    check("rst_timeout", 32'(bus.timeout), 0);
    step();
    rst_n = 1'b1;
    step();

    // Single request, exact latency and release
    bus.req = 4'b0100;
    exp_q.push_back(4'b0100);
    @(negedge clk);
    check("single_not_early", 32'(bus.gnt), 0);
    @(negedge clk);
    check("single_gnt", 32'(bus.gnt), 32'h4);
    check("single_drv", 32'(bus.drv_en_n), 32'hB);
    check("single_owner", 32'(bus.owner_id), 2);
    repeat (3) step();
    bus.last = 4'b0100;
    @(negedge clk);
    check("single_pre_release", 32'(bus.gnt), 32'h4);
    step();
    bus.req  = '0;
    bus.last = '0;
    @(negedge clk);
    check("single_release", 32'(bus.gnt), 0);
    repeat (3) @(negedge clk);
    check("single_no_regrant", 32'(bus.gnt), 0);
    check("single_owner_kept", 32'(bus.owner_id), 2);

    // Asynchronous reset in the middle of a grant
    step();
    bus.req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant("midrst_grant");
    check("midrst_gnt", 32'(bus.gnt), 32'h2);
    #2;
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    check("midrst_drv", 32'(bus.drv_en_n), 32'hF);
    check("midrst_gnt0", 32'(bus.gnt), 0);
    check("midrst_owner", 32'(bus.owner_id), 0);
    check("midrst_busy", 32'(bus.bus_busy), 0);
    step();
    rst_n = 1'b1;
    step();

    // All requesting: rotation 0,1,2,3,0 with TC idle cycles between owners
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) exp_q.push_back(4'(1 << (k % 4)));
    for (int k = 0; k < 5; k++) begin
      gap = 0;
      @(negedge clk);
      while (bus.gnt == '0 && gap < 20) begin
        gap++;
        @(negedge clk);
      end
      if (k > 0) check("all_gap", gap, TC);
      else check("all_first_grant", 32'(bus.gnt != '0), 1);
      check("all_owner", 32'(bus.owner_id), k % 4);
      step();
      bus.last = bus.gnt;
      if (k == 4) bus.req = '0;
      step();
      bus.last = '0;
    end
    repeat (4) @(negedge clk);
    check("all_idle", 32'(bus.gnt), 0);

    // Non-owner last is ignored
    step();
    bus.req = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant("nonown_grant");
    step();
    bus.last = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      check("nonown_hold", 32'(bus.gnt), 32'h1);
    end
    step();
    bus.last = '0;
    bus.req  = '0;
    @(negedge clk);
    @(negedge clk);
    check("nonown_release", 32'(bus.gnt), 0);
    repeat (3) step();

    // Owner 1 drops req while requester 3 rises
    bus.req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant("swap_grant1");
    check("swap_owner1", 32'(bus.owner_id), 1);
    step();
    bus.req = 4'b1000;
    exp_q.push_back(4'b1000);
    @(negedge clk);
    check("swap_still1", 32'(bus.gnt), 32'h2);
    @(negedge clk);
    check("swap_turn", 32'(bus.gnt), 0);
    for (int i = 1; i < TC; i++) begin
      @(negedge clk);
      check("swap_turn_n", 32'(bus.gnt), 0);
    end
    @(negedge clk);
    check("swap_grant3", 32'(bus.gnt), 32'h8);
    check("swap_owner3", 32'(bus.owner_id), 3);
    step();
    bus.req = '0;
    repeat (4) step();

`ifdef BUS_TIMEOUT_EN
    // Forced release after TO owned cycles, waiting requester 2 follows
    bus.req = 4'b0110;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    wait_grant("tmo_grant1");
    owned = 1;
    while (bus.gnt == 4'b0010 && owned < 40) begin
      @(negedge clk);
      if (bus.gnt == 4'b0010) owned++;
    end
    check("tmo_owned_cycles", owned, TO);
    check("tmo_gnt_fall", 32'(bus.gnt), 0);
    check("tmo_pulse", 32'(bus.timeout), 1);
    @(negedge clk);
    check("tmo_pulse_end", 32'(bus.timeout), 0);
    check("tmo_grant2", 32'(bus.gnt), 32'h4);
    step();
    bus.req = '0;
    repeat (4) step();
`else
    // Without the timeout option a held grant is never revoked
    bus.req = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant("hold_grant");
    repeat (TO + 8) @(negedge clk);
    check("hold_gnt", 32'(bus.gnt), 32'h1);
    check("hold_timeout", 32'(bus.timeout), 0);
    step();
    bus.req = '0;
    repeat (4) step();
`endif

    check("idle_end", 32'(bus.gnt), 0);
    check("scoreboard_empty", exp_q.size(), 0);
`ifdef BUS_TIMEOUT_EN
    check("timeout_pulses", tmo_cnt, 1);
`else
    check("timeout_pulses", tmo_cnt, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
